// File: rtl/delta_scheduler.sv
// delta_scheduler: serial output-layer backprop deltas, delta = err * a * (1 - a),
// using one shared Q-format multiplier that is time-multiplexed across states.

// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// keep the low WIDTH bits (truncation toward -inf, no saturation).
module mult_2in #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] full;
    logic                      unused_bits;

    assign full        = a * b;
    assign p           = full[FRAC +: WIDTH];
    assign unused_bits = ^{full[2*WIDTH-1:FRAC+WIDTH], full[FRAC-1:0]};
endmodule

module delta_scheduler #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_act,
    input  logic [WIDTH-1:0] i_err,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_delta,
    output logic [IDX_W-1:0] o_idx,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL1,
        MUL2,
        OUT
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] act_r;
    logic [WIDTH-1:0] err_r;
    logic [WIDTH-1:0] p1_r;
    logic [WIDTH-1:0] delta_r;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] prod;
    logic             out_fire;
    logic             last_fire;

    assign out_fire  = (state == OUT) && i_ready;
    assign last_fire = out_fire && (idx == LAST);

    // Shared multiplier: (1 - a) * a in MUL1, p1 * err in MUL2.
    always_comb begin
        ma = ONE - act_r;
        mb = act_r;
        if (state == MUL2) begin
            ma = p1_r;
            mb = err_r;
        end
    end

    mult_2in #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_mult (
        .a(ma),
        .b(mb),
        .p(prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (i_start) nstate = LOAD;
            LOAD: if (i_valid) nstate = MUL1;
            MUL1: nstate = MUL2;
            MUL2: nstate = OUT;
            OUT: begin
                if (out_fire) nstate = (idx == LAST) ? IDLE : LOAD;
            end
            default: nstate = IDLE;
        endcase
    end

    // Datapath registers, index counter and the end-of-run pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_r   <= '0;
            err_r   <= '0;
            p1_r    <= '0;
            delta_r <= '0;
            idx     <= '0;
            o_done  <= 1'b0;
        end else begin
            o_done <= last_fire;
            unique case (state)
                IDLE: if (i_start) idx <= '0;
                LOAD: begin
                    if (i_valid) begin
                        act_r <= i_act;
                        err_r <= i_err;
                    end
                end
                MUL1: p1_r <= prod;
                MUL2: delta_r <= prod;
                OUT: if (out_fire && !last_fire) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        o_ready = (state == LOAD);
        o_valid = (state == OUT);
        o_busy  = (state != IDLE);
        o_delta = delta_r;
        o_idx   = idx;
    end
endmodule

// File: doc/delta_scheduler.md
# delta_scheduler

Sequencer that computes output-layer backprop deltas, delta_k = err_k · a_k · (1 − a_k), for N neurons using one shared Q8.24 multiplier. Elements are processed serially through an input stream handshake and an output stream handshake. The block sits between the forward-pass activation/error buffers and the weight-update unit. It replaces N parallel sigmoid-derivative plus multiply datapaths with a single time-shared `mult_2in`.

## Interface
- WIDTH, 32, data width (signed fixed point)
- FRAC, 24, fractional bits; 1.0 = 1 << FRAC
- N, 4, elements per run (≥1)
- IDX_W, 2, index width; ceil(log2(N)), minimum 1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- i_start  in  1  run-start pulse; honoured only in IDLE
- i_valid  in  1  input element valid
- i_act  in  WIDTH  activation a_k (signed Q)
- i_err  in  WIDTH  error err_k (signed Q)
- o_ready  out  1  input element accepted when i_valid & o_ready
- o_valid  out  1  output delta valid
- o_delta  out  WIDTH  delta_k (signed Q)
- o_idx  out  IDX_W  index k of o_delta
- i_ready  in  1  output consumed when o_valid & i_ready
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after last delta of a run is consumed

## Operation
- One combinational `mult_2in` (WIDTH, FRAC) is shared and muxed by state.
- Multiply rule: full 2·WIDTH signed product, arithmetic shift right by FRAC, low WIDTH bits kept. This is truncation toward −inf, no saturation, no rounding.
- Registers: act_r, err_r, p1_r, delta_r (all WIDTH), idx (IDX_W).
- States:
  - IDLE: o_busy=0. On i_start=1, go to LOAD and set idx to 0.
  - LOAD: o_ready=1. On i_valid, latch act_r←i_act and err_r←i_err, then go to MUL1.
  - MUL1: multiplier inputs are (ONE − act_r, act_r); p1_r ← product. Go to MUL2. ONE − act_r is WIDTH-bit wraparound subtraction.
  - MUL2: multiplier inputs are (p1_r, err_r); delta_r ← product. Go to OUT.
  - OUT: o_valid=1, o_delta=delta_r, o_idx=idx. On i_ready:
    - if idx==N−1, assert o_done next cycle and go to IDLE;
    - otherwise idx←idx+1 and go to LOAD.
- o_ready is high only in LOAD. o_valid is high only in OUT. Both are decoded from state.
- i_start outside IDLE is ignored and has no effect on the current run.
- i_valid outside LOAD is ignored; no data is latched.
- o_delta and o_idx stay stable while o_valid=1 and i_ready=0.
- No input range check. a outside [0,1] is computed per the wraparound and truncation rules.

## Timing
- Reset values: state=IDLE, o_ready=0, o_valid=0, o_busy=0, o_done=0, o_delta=0, o_idx=0. All internal registers are 0.
- rst wins over every other input in the same cycle. Reset mid-run abandons the run: no o_done pulse, and the partial index is lost.
- i_start sampled at edge t puts the block in LOAD during cycle t+1.
- Input accepted at edge t gives MUL1 in t+1, MUL2 in t+2, and o_valid=1 from t+3.
- Element latency is 3 cycles from accept to o_valid. With no backpressure, throughput is one element per 4 cycles.
- Output handshake at edge t with the last element: o_done=1 and state=IDLE during t+1, and o_busy=0 in t+1.
- New i_start is accepted in the same cycle o_done=1, because the block is in IDLE.
- Input and output handshakes never coincide, since LOAD and OUT are distinct states.

## Test plan
- Single element: N=1, start; act=0x00800000 (0.5), err=0x01000000 (1.0). Expect o_delta=0x00400000 exactly 3 cycles after accept, o_idx=0, then an o_done pulse one cycle after consume.
- Negative error: act=0x00400000 (0.25), err=0xFF000000 (−1.0). Expect o_delta=0xFFD00000 (−0.1875).
- Boundaries: act=0x00000000 → 0; act=0x01000000 → 0; act=0x00000001 with err=1.0 → 0 (truncation).
- Full run N=4 with random i_valid gaps and i_ready stalls of 0–5 cycles. Expect o_idx 0,1,2,3 in order and o_delta matching the golden model. Outputs are held stable during stalls. Exactly one o_done, and i_start pulses mid-run are ignored.
- Backpressure: hold i_ready=0 for 10 cycles in OUT. Expect o_valid held, o_ready=0, and no new input accepted even with i_valid=1.
- Reset mid-run: assert rst during MUL2 of element 2. The next cycle shows all outputs at reset values and no o_done. A new start then processes from idx 0.
